// File: rtl/game_input_conditioner.sv
// Button front-end for the Astro Barrier game logic: synchronises and debounces
// the three push-buttons and produces the game tick, movement levels and fire event.
module game_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_DIV        = 2097152,
  parameter int CNT_W           = 24,
  parameter int TICK_W          = 22
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       btnL_raw,
  input  logic       btnR_raw,
  input  logic       btnU_raw,
  output logic       tick,
  output logic       move_left,
  output logic       move_right,
  output logic       fire_evt,
  output logic [2:0] btn_db
);

  logic [2:0]        raw;
  logic [2:0]        s1;
  logic [2:0]        s2;
  logic [2:0]        db;
  logic [CNT_W-1:0]  cnt [3];
  logic [TICK_W-1:0] tc;
  logic              tick_next;
  logic              dbu_d;
  logic              fire_pend;
  logic              fire_rise;

  assign raw    = {btnU_raw, btnR_raw, btnL_raw};
  assign btn_db = db;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Each button's counter only advances while the synchronised level disagrees
  // with the stable level, so any bounce back restarts the hold period.
  for (genvar i = 0; i < 3; i++) begin : g_debounce
    always_ff @(posedge board_clk or posedge reset) begin
      if (reset) begin
        cnt[i] <= '0;
        db[i]  <= 1'b0;
      end else if (s2[i] == db[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        db[i]  <= s2[i];
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  assign tick_next = (tc == TICK_W'(TICK_DIV - 1));
  assign fire_rise = db[2] & ~dbu_d;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      tc   <= '0;
      tick <= 1'b0;
    end else begin
      tc   <= tick_next ? '0 : tc + TICK_W'(1);
      tick <= tick_next;
    end
  end

  // A rise seen on the consuming cycle keeps the request pending for the next tick.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      dbu_d     <= 1'b0;
      fire_pend <= 1'b0;
      fire_evt  <= 1'b0;
    end else begin
      dbu_d     <= db[2];
      fire_pend <= fire_rise | (fire_pend & ~tick_next);
      fire_evt  <= tick_next & fire_pend;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      move_left  <= 1'b0;
      move_right <= 1'b0;
    end else begin
      move_left  <= db[0] & ~db[1];
      move_right <= db[1] & ~db[0];
    end
  end

endmodule
